regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with a per-register busy scoreboard and a sequential clear engine, for the multi-issue pipeline's decode/writeback boundary. It provides NRP asynchronous read ports with write-through bypass and NWP synchronous write ports with fixed priority. Each register carries a busy bit, set at issue and cleared at writeback, which decode uses for hazard detection. A clear request walks the array one entry per cycle and restores reset values without asserting rst.

## Interface
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥4); AW = $clog2(NREGS)
- NRP, 3, read ports (≥1)
- NWP, 2, write ports (≥1)
- SP_IDX, 29, index loaded with SP_INIT at reset/clear
- SP_INIT, 32'h100, stack pointer reset value
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRP*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NRP*XLEN  read data, combinational
- rd_busy  out  NRP  busy bit of each read address, combinational
- wr_en  in  NWP  write enables
- wr_addr  in  NWP*AW  write addresses
- wr_data  in  NWP*XLEN  write data
- iss_en  in  1  issue: mark iss_addr busy
- iss_addr  in  AW  destination register of issued instruction
- clr_req  in  1  start clear sweep (single-cycle pulse sufficient)
- clr_busy  out  1  sweep in progress
- ready  out  1  = !clr_busy; port writes and issues accepted only when 1

## Operation
- Register 0 is hardwired: reads return 0, rd_busy 0, writes/issues to 0 are discarded.
- Writes: on each edge with ready=1, every wr_en[w] with wr_addr[w]≠0 updates the entry. When several ports share an address, the highest port index wins.
- Reads: rd_data[p] = entry[rd_addr[p]]. If any enabled write (ready=1) targets the same nonzero address, rd_data[p] = that write's data, highest index wins.
- Scoreboard: busy[wr_addr[w]] clears on write. busy[iss_addr] sets on iss_en. When an issue and a write target the same address in the same cycle, the issue wins and busy stays 1 (new producer).
- rd_busy[p] = busy[rd_addr[p]] && !(same-cycle enabled write to rd_addr[p]). Bypass covers the hazard.
- Reset (rst=1 at edge): all entries 0, entry SP_IDX = SP_INIT, all busy 0, FSM → IDLE. Reset overrides everything, including a sweep in progress.
- FSM states:
  - IDLE: clr_req=1 → SWEEP, idx←0, all busy bits cleared at the same edge.
  - SWEEP: each cycle, entry[idx] ← (idx==SP_IDX ? SP_INIT : 0) and idx←idx+1. After idx=NREGS-1 → IDLE.
- While in SWEEP:
  - wr_en and iss_en are ignored, with no bypass.
  - clr_req is ignored.
  - Reads return current array contents, so partially swept values are visible.
- idx is AW bits wide; termination is on idx==NREGS-1, not on wrap.

## Timing
- Read latency 0 (combinational from rd_addr/wr_*). Write visible in array from the edge after wr_en.
- Issue → rd_busy=1 on the following cycle.
- Sweep length: clr_busy high for exactly NREGS cycles, starting the cycle after the clr_req edge. ready returns 1 in cycle NREGS+1.
- clr_req and port writes in the same IDLE cycle: the writes are performed at that edge, then the sweep overwrites them.
- Reset values: clr_busy=0, ready=1, rd_busy=0 for all ports. rd_data = 0, except SP_INIT when addressing SP_IDX.

## Test plan
- Reset, then read ports at 0/29/5 → rd_data 0 / 32'h100 / 0. All rd_busy 0, ready 1.
- wr0 (r5←32'hAAAA) and wr1 (r5←32'h5555) in the same cycle, ra1=5 → same-cycle rd_data 32'h5555. Next cycle array r5 = 32'h5555.
- Issue r7. Next cycle rd_busy=1. Write r7←32'h1234 → same-cycle rd_busy 0, rd_data 32'h1234. Following cycle busy 0.
- Issue r9 and write r9 in the same cycle → busy[9]=1 afterward, with the data written.
- Fill r1..r31 with nonzero values, pulse clr_req → clr_busy high for 32 cycles, writes during the sweep are ignored. Afterward all entries 0 except r29=32'h100.
- Assert rst at sweep cycle 10 → next cycle IDLE, ready=1, full reset values everywhere.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write ports, issue and clear control.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 3,
  parameter int NWP   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                clr_req;
  logic                clr_busy;
  logic                ready;

  // Pipeline side drives addresses, writes, issues and clear requests.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
    input  rd_data, rd_busy, clr_busy, ready
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
    output rd_data, rd_busy, clr_busy, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard and a
// one-entry-per-cycle clear sweep that restores reset values.
module regfile_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter int              NRP     = 3,
  parameter int              NWP     = 2,
  parameter int              SP_IDX  = 29,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h100)
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int            AW   = $clog2(NREGS);
  localparam logic [AW-1:0] SP_A = AW'(SP_IDX);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nxt;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    idx;
  logic             ready;
  logic [NRP-1:0]   byp;

  assign ready        = (state == IDLE);
  assign bus.ready    = ready;
  assign bus.clr_busy = (state == SWEEP);

  // Next-state: start a sweep on request, leave after the last entry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_req) state_nxt = SWEEP;
      SWEEP:   if (idx == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Array, scoreboard, sweep index and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is flops, not a RAM macro, so every entry is reset
      // explicitly; a RAM could not be cleared in one edge like this.
      for (int i = 0; i < NREGS; i++) regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      busy  <= '0;
      idx   <= '0;
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments here; later ports in the loop override
      // earlier ones to the same entry, which gives highest-index priority.
      state <= state_nxt;
      if (state == SWEEP) begin
        regs[idx] <= (idx == SP_A) ? SP_INIT : '0;
        idx       <= idx + 1'b1;
      end else begin
        for (int w = 0; w < NWP; w++) begin
          if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0) begin
            regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
            busy[bus.wr_addr[w*AW +: AW]] <= 1'b0;
          end
        end
        // A same-cycle issue names a new producer, so it beats the write.
        if (bus.iss_en && bus.iss_addr != '0) busy[bus.iss_addr] <= 1'b1;
        // Starting a sweep drops every pending producer.
        if (bus.clr_req) begin
          busy <= '0;
          idx  <= '0;
        end
      end
    end
  end

  // Read ports: array value, overridden by a same-cycle accepted write.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    bus.rd_data = '0;
    bus.rd_busy = '0;
    byp         = '0;
    for (int p = 0; p < NRP; p++) begin
      bus.rd_data[p*XLEN +: XLEN] = regs[bus.rd_addr[p*AW +: AW]];
      for (int w = 0; w < NWP; w++) begin
        if (ready && bus.wr_en[w] &&
            bus.wr_addr[w*AW +: AW] == bus.rd_addr[p*AW +: AW]) begin
          bus.rd_data[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
          byp[p] = 1'b1;
        end
      end
      if (bus.rd_addr[p*AW +: AW] == '0) bus.rd_data[p*XLEN +: XLEN] = '0;
      bus.rd_busy[p] = busy[bus.rd_addr[p*AW +: AW]] && !byp[p] &&
                       (bus.rd_addr[p*AW +: AW] != '0);
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, random traffic
// against a behavioural model, clear sweep and reset-during-sweep sequences.
module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRP = 3, NWP = 2, AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP),
               .SP_IDX(29), .SP_INIT(32'h100)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [NREGS];
  bit          m_busy [NREGS];
  int          m_sweep_left;   // sweep cycles still to go; 0 = accepting traffic

  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = (i == 29) ? 32'h100 : 32'h0;
      m_busy[i] = 1'b0;
    end
    m_sweep_left = 0;
  endfunction

  // Applies the inputs present at a rising edge to the model.
  function automatic void m_update();
    if (rst) begin
      m_reset();
    end else if (m_sweep_left > 0) begin
      int k;
      k = NREGS - m_sweep_left;
      m_reg[k] = (k == 29) ? 32'h100 : 32'h0;
      m_sweep_left--;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        int a;
        a = int'(bus.wr_addr[w*AW +: AW]);
        if (bus.wr_en[w] && a != 0) begin
          m_reg[a]  = bus.wr_data[w*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
      if (bus.clr_req) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        m_sweep_left = NREGS;
      end
    end
  endfunction

  function automatic void m_read(input logic [AW-1:0] a, output logic [31:0] d, output bit b);
    bit hit;
    hit = 1'b0;
    d   = m_reg[a];
    if (m_sweep_left == 0)
      for (int w = 0; w < NWP; w++)
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) begin
          d   = bus.wr_data[w*XLEN +: XLEN];
          hit = 1'b1;
        end
    if (a == 0) d = 32'h0;
    b = m_busy[a] && !hit && (a != 0);
  endfunction

  // ---------------- helpers ----------------
  task automatic drive_idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d;
    bit          b;
    for (int p = 0; p < NRP; p++) begin
      m_read(bus.rd_addr[p*AW +: AW], d, b);
      check($sformatf("%s_data%0d", tag, p), bus.rd_data[p*XLEN +: XLEN], d);
      check($sformatf("%s_busy%0d", tag, p), 32'(bus.rd_busy[p]), 32'(b));
    end
    check({tag, "_ready"}, 32'(bus.ready), 32'(m_sweep_left == 0));
    check({tag, "_clrbusy"}, 32'(bus.clr_busy), 32'(m_sweep_left != 0));
  endtask

  // Reads every register on all ports against fixed reset values.
  task automatic check_reset_values(input string tag);
    drive_idle();
    #1;
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_clrbusy"}, 32'(bus.clr_busy), 32'd0);
    for (int a = 0; a < NREGS; a++) begin
      bus.rd_addr = {AW'(a), AW'(a), AW'(a)};
      #1;
      for (int p = 0; p < NRP; p++) begin
        check($sformatf("%s_r%0d_p%0d", tag, a, p), bus.rd_data[p*XLEN +: XLEN],
              (a == 29) ? 32'h100 : 32'h0);
        check($sformatf("%s_b%0d_p%0d", tag, a, p), 32'(bus.rd_busy[p]), 32'd0);
      end
    end
  endtask

  task automatic fill_regs(input int lo, input int hi);
    for (int a = lo; a <= hi; a += 2) begin
      bus.wr_en   = 2'b11;
      bus.wr_addr = {AW'((a + 1 <= hi) ? a + 1 : 0), AW'(a)};
      bus.wr_data = {$urandom | 32'h1, $urandom | 32'h1};
      step();
    end
    drive_idle();
  endtask

  task automatic random_traffic();
    bus.wr_en    = 2'($urandom);
    bus.wr_addr  = {AW'($urandom), AW'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
    bus.wr_data  = {$urandom, $urandom};
    bus.iss_en   = ($urandom_range(0, 2) == 0);
    bus.iss_addr = AW'($urandom);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] ed0, ed1, ed2;
    logic [2:0]  eb;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic ie, input logic [4:0] ia,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic [31:0] ed0, input logic [31:0] ed1, input logic [31:0] ed2,
                               input logic [2:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.ed0 = ed0; v.ed1 = ed1; v.ed2 = ed2; v.eb = eb;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = mkv(2'b00, 0, 0, 0, 0, 0, 0, 0, 29, 5, 32'h0, 32'h100, 32'h0, 3'b000);
    vecs[1]  = mkv(2'b11, 5, 32'hAAAA, 5, 32'h5555, 0, 0, 29, 5, 0, 32'h100, 32'h5555, 32'h0, 3'b000);
    vecs[2]  = mkv(2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 0, 32'h5555, 32'h0, 32'h0, 3'b000);
    vecs[3]  = mkv(2'b00, 0, 0, 0, 0, 1, 7, 7, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000);
    vecs[4]  = mkv(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 0, 32'h0, 32'h0, 32'h0, 3'b001);
    vecs[5]  = mkv(2'b01, 7, 32'h1234, 0, 0, 0, 0, 7, 5, 0, 32'h1234, 32'h5555, 32'h0, 3'b000);
    vecs[6]  = mkv(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 0, 32'h1234, 32'h0, 32'h0, 3'b000);
    vecs[7]  = mkv(2'b10, 0, 0, 9, 32'hABCD, 1, 9, 9, 7, 0, 32'hABCD, 32'h1234, 32'h0, 3'b000);
    vecs[8]  = mkv(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 32'hABCD, 32'h0, 32'h0, 3'b001);
    vecs[9]  = mkv(2'b01, 0, 32'hFFFF, 0, 0, 1, 0, 0, 9, 0, 32'h0, 32'hABCD, 32'h0, 3'b010);
    vecs[10] = mkv(2'b11, 3, 32'h33, 4, 32'h44, 0, 0, 3, 4, 9, 32'h33, 32'h44, 32'hABCD, 3'b100);
    vecs[11] = mkv(2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 0, 32'h33, 32'h44, 32'h0, 3'b000);

    rst = 1'b1;
    drive_idle();
    bus.rd_addr = '0;
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.wr_en    = vecs[i].we;
      bus.wr_addr  = {vecs[i].wa1, vecs[i].wa0};
      bus.wr_data  = {vecs[i].wd1, vecs[i].wd0};
      bus.iss_en   = vecs[i].ie;
      bus.iss_addr = vecs[i].ia;
      bus.rd_addr  = {vecs[i].ra2, vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_d0", i), bus.rd_data[31:0],  vecs[i].ed0);
      check($sformatf("vec%0d_d1", i), bus.rd_data[63:32], vecs[i].ed1);
      check($sformatf("vec%0d_d2", i), bus.rd_data[95:64], vecs[i].ed2);
      check($sformatf("vec%0d_busy", i), 32'(bus.rd_busy), 32'(vecs[i].eb));
      check($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'd1);
      step();
    end
    drive_idle();

    // Random traffic with occasional clears and resets.
    for (int c = 0; c < 400; c++) begin
      random_traffic();
      bus.clr_req = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NRP; p++)
        bus.rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 0) ? bus.wr_addr[($urandom_range(0, 1))*AW +: AW]
                                                              : AW'($urandom);
      #1;
      check_model($sformatf("rnd%0d", c));
      step();
    end
    rst = 1'b0;
    drive_idle();
    n = 0;
    while (!bus.ready && n < 40) begin
      step();
      n++;
    end
    check("settle_ready", 32'(bus.ready), 32'd1);

    // Full sweep: fill, clear together with a write and issue, traffic during it.
    fill_regs(1, 31);
    bus.clr_req  = 1'b1;
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {AW'(0), AW'(6)};
    bus.wr_data  = {32'h0, 32'hDEAD};
    bus.iss_en   = 1'b1;
    bus.iss_addr = AW'(6);
    step();
    drive_idle();
    n = 0;
    while (bus.clr_busy && n < 40) begin
      random_traffic();
      bus.clr_req = 1'b1;
      bus.rd_addr = {AW'($urandom), AW'(n), bus.wr_addr[AW-1:0]};
      #1;
      check($sformatf("sweep%0d_ready", n), 32'(bus.ready), 32'd0);
      check_model($sformatf("sweep%0d", n));
      step();
      n++;
    end
    check("sweep_len", 32'(n), 32'd32);
    check_reset_values("after_sweep");

    // Reset while the sweep is at cycle 10.
    fill_regs(1, 31);
    bus.clr_req = 1'b1;
    step();
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      random_traffic();
      step();
    end
    check("mid_sweep_busy", 32'(bus.clr_busy), 32'd1);
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
